cap_regctrl_mc: RTL and testbench
=================================

CAP_REGCTRL_MC -- requirements
Module: cap_regctrl_mc

Interface
REQ-001 SHALL have parameter NCH, default 2, number of capture channels (legal 1..4).
REQ-002 SHALL have parameter BLKID, default 4'd1, value of WRADDR/RDADDR[15:12] that selects this block.
REQ-003 SHALL have these ports:
- ACLK  in  1  the single clock; all state changes on its rising edge.
- ARST  in  1  reset, asynchronous assert, active-low.
- VSYNC  in  NCH  per-channel vertical sync, asynchronous to ACLK.
- WRADDR  in  16  write address.
- BYTEEN  in  4  write byte enables.
- WREN  in  1  write strobe.
- WDATA  in  32  write data.
- RDADDR  in  16  read address.
- RDEN  in  1  read strobe.
- RDATA  out  32  registered read data.
- CAPON  out  NCH  per-channel capture enable, frame-aligned.
- CAPADDR  out  29*NCH  per-channel frame base address, frame-aligned; channel n in bits [29n+28:29n].
- CAP_IRQ  out  1  combined interrupt request.
- BUF_UNDER  in  NCH  per-channel FIFO underflow pulse.
- BUF_OVER  in  NCH  per-channel FIFO overflow pulse.

Function
REQ-004 SHALL decode accesses as follows:
- Block hit: addr[15:12]==BLKID.
- Channel: addr[11:8]; channels >= NCH are ignored on write and read as 0.
- Register: addr[7:2]; 0=CAPADDR, 1=CAPCTRL, 2=CAPINT, 3=CAPFIFO, 4=FRMCNT; other offsets are ignored on write and read as 0.
REQ-005 SHALL synchronise each VSYNC through 2 flops plus 1 history flop; vne[n] is high for one cycle when history=1 and sync=0 (3rd rising edge of ACLK after the fall).
REQ-006 SHALL hold a per-channel staging CAPADDR register, byte-writable (byte 3 writes bits 28:24 only). CAPADDR reads return the staging value.
REQ-007 SHALL copy staging CAPADDR to the CAPADDR output on vne[n]. If a write and vne[n] occur in the same cycle, the output takes the old staging value and staging takes the new data.
REQ-008 SHALL treat CAPCTRL as follows (written when BYTEEN[0]=1):
- bit0 CAPREQ: read/write.
- bit1 CBLANK: set by vne[n]; cleared by writing 1. Set wins over a simultaneous clear.
- The CAPON[n] output loads CAPREQ on vne[n] only.
REQ-009 SHALL treat CAPINT as follows:
- bit0 VIE: read/write.
- bit1 VINT: set on vne[n] when VIE=1; write-1-to-clear.
- bit2 EIE: read/write.
- bit3 EINT: set on BUF_OVER[n] or BUF_UNDER[n] when EIE=1; write-1-to-clear.
- Set wins over a simultaneous clear.
REQ-010 SHALL treat CAPFIFO as follows: bit0 FIFOUNDER and bit1 FIFOOVER are sticky, set by their pulse, write-1-to-clear, and set wins over a simultaneous clear.
REQ-011 SHALL register CAP_IRQ as the OR over all channels of VINT|EINT; it follows the status bits with 1 cycle of latency.
REQ-012 SHALL update RDATA one cycle after RDEN=1. RDATA holds its value when RDEN=0 or on a block miss; unused bits read as 0.
REQ-013 SHALL handle a write and a read to the same register in the same cycle by returning the pre-write value.

Reset
REQ-014 SHALL, while ARST=0, asynchronously clear all outputs, registers, synchronisers and counters to 0.
REQ-015 SHALL produce no vne pulse from the reset release itself; synchroniser history resets to 0.
REQ-016 SHALL, if reset is asserted mid-frame, zero CAPON and CAPADDR immediately without waiting for a frame boundary.

Configuration
REQ-017 SHALL, with CAP_FRMCNT_EN defined, implement FRMCNT per channel:
- 16-bit counter, increments on vne[n] while CAPON[n]=1.
- Wraps from 0xFFFF to 0x0000.
- Any write with BYTEEN!=0 clears it to 0; an increment in the same cycle is lost.
REQ-018 SHALL, without CAP_FRMCNT_EN, omit the counter logic; offset 4 then reads 0 and ignores writes.

Verification
REQ-019 SHALL cover: write ch0 CAPADDR=0x1234_5678 then drop VSYNC0 -> CAPADDR[28:0] stays 0 until vne, then becomes 0x1234_5678; readback returns 0x1234_5678 immediately after the write.
REQ-020 SHALL cover: write ch1 CAPCTRL=1 mid-frame -> CAPON[1]=0 until the next VSYNC1 fall, then 1; CBLANK reads 1 after the fall; writing 2 clears CBLANK.
REQ-021 SHALL cover: ch0 VIE=1, VSYNC0 fall -> VINT=1 and CAP_IRQ=1 one cycle later; W1C of bit1 in the same cycle as the next vne -> VINT remains 1.
REQ-022 SHALL cover: BUF_OVER[1] pulse with EIE=0 -> CAPFIFO reads 0x2 and CAP_IRQ stays 0; with EIE=1 -> EINT=1 and CAP_IRQ=1.
REQ-023 SHALL cover: with CAP_FRMCNT_EN, CAPON=1, 65537 VSYNC falls -> FRMCNT reads 1; a read of channel 3 with NCH=2 -> 0.
REQ-024 SHALL cover: ARST pulse low mid-frame with CAPON=1 -> all outputs 0 asynchronously and no vne on release.

Source files
------------

// File: rtl/cap_regctrl_mc_if.sv
// Register bus between a host and cap_regctrl_mc: independent write and read
// ports; RDATA is driven by the slave one cycle after a read strobe.
interface cap_regctrl_mc_if;
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDATA;

  modport master (
    output WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
    input  RDATA
  );

  modport slave (
    input  WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
    output RDATA
  );
endinterface

// File: rtl/cap_regctrl_mc.sv
// Multi-channel capture register controller: frame-aligned capture enable and
// base address per channel, status/interrupts. Define CAP_FRMCNT_EN for FRMCNT.
module cap_regctrl_mc #(
  parameter int          NCH   = 2,
  parameter logic [3:0]  BLKID = 4'd1
) (
  input  logic                 ACLK,
  input  logic                 ARST,
  input  logic [NCH-1:0]       VSYNC,
  cap_regctrl_mc_if.slave      bus,
  output logic [NCH-1:0]       CAPON,
  output logic [29*NCH-1:0]    CAPADDR,
  output logic                 CAP_IRQ,
  input  logic [NCH-1:0]       BUF_UNDER,
  input  logic [NCH-1:0]       BUF_OVER
);

  localparam logic [5:0] OFF_CAPADDR = 6'd0;
  localparam logic [5:0] OFF_CAPCTRL = 6'd1;
  localparam logic [5:0] OFF_CAPINT  = 6'd2;
  localparam logic [5:0] OFF_CAPFIFO = 6'd3;
  localparam logic [5:0] OFF_FRMCNT  = 6'd4;

  logic [NCH-1:0]     sync1_reg, sync2_reg, hist_reg, vne;
  logic               wr_hit, rd_hit;
  logic [3:0]         wr_ch, rd_ch;
  logic [5:0]         wr_off, rd_off;
  logic [32*NCH-1:0]  ch_rdata;
  logic [NCH-1:0]     ch_irq;
  logic [31:0]        rd_word;
  logic [31:0]        rdata_reg;
  logic               irq_reg;
  logic               unused_bits;

  // Two-flop synchroniser plus history flop; history resets low so a release
  // with VSYNC already high never looks like a falling edge.
  always_ff @(posedge ACLK or negedge ARST) begin
    if (!ARST) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      hist_reg  <= '0;
    end else begin
      sync1_reg <= VSYNC;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
    end
  end

  assign vne = hist_reg & ~sync2_reg;

  assign wr_hit = bus.WREN && (bus.WRADDR[15:12] == BLKID);
  assign wr_ch  = bus.WRADDR[11:8];
  assign wr_off = bus.WRADDR[7:2];
  assign rd_hit = bus.RDEN && (bus.RDADDR[15:12] == BLKID);
  assign rd_ch  = bus.RDADDR[11:8];
  assign rd_off = bus.RDADDR[7:2];

  assign unused_bits = ^{bus.WRADDR[1:0], bus.RDADDR[1:0], bus.WDATA[31:29]};

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic        wr_sel;
      logic        wr_addr, wr_ctrl, wr_int, wr_fifo;
      logic [28:0] stage_reg, capaddr_reg;
      logic        capreq_reg, capon_reg, cblank_reg;
      logic        vie_reg, vint_reg, eie_reg, eint_reg;
      logic        under_reg, over_reg;
      logic [15:0] frm_val;
      logic [31:0] word_next;

      assign wr_sel  = wr_hit && (wr_ch == 4'(gi));
      assign wr_addr = wr_sel && (wr_off == OFF_CAPADDR);
      assign wr_ctrl = wr_sel && (wr_off == OFF_CAPCTRL) && bus.BYTEEN[0];
      assign wr_int  = wr_sel && (wr_off == OFF_CAPINT)  && bus.BYTEEN[0];
      assign wr_fifo = wr_sel && (wr_off == OFF_CAPFIFO) && bus.BYTEEN[0];

      // The output copy samples staging before this cycle's write lands.
      always_ff @(posedge ACLK or negedge ARST) begin
        if (!ARST) begin
          stage_reg   <= '0;
          capaddr_reg <= '0;
          capreq_reg  <= 1'b0;
          capon_reg   <= 1'b0;
          cblank_reg  <= 1'b0;
          vie_reg     <= 1'b0;
          vint_reg    <= 1'b0;
          eie_reg     <= 1'b0;
          eint_reg    <= 1'b0;
          under_reg   <= 1'b0;
          over_reg    <= 1'b0;
        end else begin
          if (vne[gi]) begin
            capaddr_reg <= stage_reg;
            capon_reg   <= capreq_reg;
          end
          if (wr_addr) begin
            if (bus.BYTEEN[0]) stage_reg[7:0]   <= bus.WDATA[7:0];
            if (bus.BYTEEN[1]) stage_reg[15:8]  <= bus.WDATA[15:8];
            if (bus.BYTEEN[2]) stage_reg[23:16] <= bus.WDATA[23:16];
            if (bus.BYTEEN[3]) stage_reg[28:24] <= bus.WDATA[28:24];
          end
          if (wr_ctrl) capreq_reg <= bus.WDATA[0];
          if (vne[gi])                         cblank_reg <= 1'b1;
          else if (wr_ctrl && bus.WDATA[1])    cblank_reg <= 1'b0;

          if (wr_int) begin
            vie_reg <= bus.WDATA[0];
            eie_reg <= bus.WDATA[2];
          end
          if (vne[gi] && vie_reg)              vint_reg <= 1'b1;
          else if (wr_int && bus.WDATA[1])     vint_reg <= 1'b0;
          if ((BUF_OVER[gi] || BUF_UNDER[gi]) && eie_reg) eint_reg <= 1'b1;
          else if (wr_int && bus.WDATA[3])     eint_reg <= 1'b0;

          if (BUF_UNDER[gi])                   under_reg <= 1'b1;
          else if (wr_fifo && bus.WDATA[0])    under_reg <= 1'b0;
          if (BUF_OVER[gi])                    over_reg <= 1'b1;
          else if (wr_fifo && bus.WDATA[1])    over_reg <= 1'b0;
        end
      end

`ifdef CAP_FRMCNT_EN
      logic        wr_frm;
      logic [15:0] frmcnt_reg;

      assign wr_frm = wr_sel && (wr_off == OFF_FRMCNT) && (bus.BYTEEN != 4'd0);

      // A clearing write beats a same-cycle increment.
      always_ff @(posedge ACLK or negedge ARST) begin
        if (!ARST) begin
          frmcnt_reg <= '0;
        end else if (wr_frm) begin
          frmcnt_reg <= '0;
        end else if (vne[gi] && capon_reg) begin
          frmcnt_reg <= frmcnt_reg + 16'd1;
        end
      end
      assign frm_val = frmcnt_reg;
`else
      assign frm_val = '0;
`endif

      always_comb begin
        word_next = '0;
        case (rd_off)
          OFF_CAPADDR: word_next[28:0] = stage_reg;
          OFF_CAPCTRL: word_next[1:0]  = {cblank_reg, capreq_reg};
          OFF_CAPINT:  word_next[3:0]  = {eint_reg, eie_reg, vint_reg, vie_reg};
          OFF_CAPFIFO: word_next[1:0]  = {over_reg, under_reg};
          OFF_FRMCNT:  word_next[15:0] = frm_val;
          default:     word_next = '0;
        endcase
      end

      assign ch_rdata[32*gi +: 32]  = word_next;
      assign ch_irq[gi]             = vint_reg | eint_reg;
      assign CAPON[gi]              = capon_reg;
      assign CAPADDR[29*gi +: 29]   = capaddr_reg;
    end
  endgenerate

  // Channels without hardware fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch == 4'(i)) rd_word = ch_rdata[32*i +: 32];
    end
  end

  always_ff @(posedge ACLK or negedge ARST) begin
    if (!ARST) begin
      rdata_reg <= '0;
      irq_reg   <= 1'b0;
    end else begin
      if (rd_hit) rdata_reg <= rd_word;
      irq_reg <= |ch_irq;
    end
  end

  assign bus.RDATA = rdata_reg;
  assign CAP_IRQ   = irq_reg;

endmodule

// File: tb/tb_cap_regctrl_mc.sv
// Bench for cap_regctrl_mc: read results go through an expected-value queue,
// frame-aligned outputs and the interrupt line are checked inline per test.
module tb_cap_regctrl_mc;
  localparam int NCH = 2;

  logic                ACLK = 1'b0;
  logic                ARST = 1'b0;
  logic [NCH-1:0]      VSYNC = '1;
  logic [NCH-1:0]      CAPON;
  logic [29*NCH-1:0]   CAPADDR;
  logic                CAP_IRQ;
  logic [NCH-1:0]      BUF_UNDER = '0;
  logic [NCH-1:0]      BUF_OVER = '0;

  cap_regctrl_mc_if bus();

  cap_regctrl_mc #(.NCH(NCH), .BLKID(4'd1)) dut (
    .ACLK(ACLK), .ARST(ARST), .VSYNC(VSYNC), .bus(bus),
    .CAPON(CAPON), .CAPADDR(CAPADDR), .CAP_IRQ(CAP_IRQ),
    .BUF_UNDER(BUF_UNDER), .BUF_OVER(BUF_OVER)
  );

  always #5 ACLK = ~ACLK;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_pend;

  // Read scoreboard: RDATA is due one edge after a cycle with RDEN high.
  always @(posedge ACLK or negedge ARST) begin
    if (!ARST) rd_pend <= 1'b0;
    else       rd_pend <= bus.RDEN;
  end

  always @(negedge ACLK) begin
    if (rd_pend) begin
      logic [31:0] e;
      string       nm;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: got %h required no read", bus.RDATA);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (bus.RDATA !== e) begin
          n_err++;
          $display("FAIL %s: got %h required %h", nm, bus.RDATA, e);
        end else begin
          $display("read %s: %h", nm, bus.RDATA);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.WRADDR = a; bus.BYTEEN = be; bus.WDATA = d; bus.WREN = 1'b1;
    tick(1);
    bus.WREN = 1'b0;
    $display("write %h be=%b data=%h", a, be, d);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] e, input string nm);
    bus.RDADDR = a; bus.RDEN = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick(1);
    bus.RDEN = 1'b0;
  endtask

  task automatic test_reset;
    bus.WRADDR = '0; bus.BYTEEN = '0; bus.WDATA = '0; bus.WREN = 1'b0;
    bus.RDADDR = '0; bus.RDEN = 1'b0;
    #23;
    n_vec++; if (CAPON !== '0)   begin n_err++; $display("FAIL rst_capon: got %b required 0", CAPON); end
    n_vec++; if (CAPADDR !== '0) begin n_err++; $display("FAIL rst_capaddr: got %h required 0", CAPADDR); end
    n_vec++; if (CAP_IRQ !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b required 0", CAP_IRQ); end
    n_vec++; if (bus.RDATA !== '0) begin n_err++; $display("FAIL rst_rdata: got %h required 0", bus.RDATA); end
    ARST = 1'b1;
    tick(5);
    rd(16'h1000, 32'h0, "rst_capaddr_stage");
    rd(16'h1004, 32'h0, "rst_capctrl_no_vne");
  endtask

  task automatic test_capaddr;
    wr(16'h1000, 4'hF, 32'h1234_5678);
    rd(16'h1000, 32'h1234_5678, "capaddr_readback");
    n_vec++; if (CAPADDR[28:0] !== 29'h0) begin n_err++; $display("FAIL capaddr_before_fall: got %h required 0", CAPADDR[28:0]); end
    VSYNC[0] = 1'b0;
    tick(2);
    n_vec++; if (CAPADDR[28:0] !== 29'h0) begin n_err++; $display("FAIL capaddr_before_vne: got %h required 0", CAPADDR[28:0]); end
    tick(1);
    n_vec++; if (CAPADDR[28:0] !== 29'h1234_5678) begin n_err++; $display("FAIL capaddr_on_vne: got %h required 12345678", CAPADDR[28:0]); end
    VSYNC[0] = 1'b1;
    tick(3);
    wr(16'h1000, 4'b0001, 32'hFFFF_FFAB);
    rd(16'h1000, 32'h1234_56AB, "capaddr_byte0");
    wr(16'h1000, 4'b1000, 32'hFFFF_FFFF);
    rd(16'h1000, 32'h1F34_56AB, "capaddr_byte3_limit");
    // Write lands on the same edge as vne: output gets the old staging value.
    VSYNC[0] = 1'b0;
    tick(2);
    wr(16'h1000, 4'hF, 32'h0ABC_DEF0);
    n_vec++; if (CAPADDR[28:0] !== 29'h1F34_56AB) begin n_err++; $display("FAIL capaddr_collision_out: got %h required 1f3456ab", CAPADDR[28:0]); end
    rd(16'h1000, 32'h0ABC_DEF0, "capaddr_collision_stage");
    VSYNC[0] = 1'b1;
    tick(3);
    bus.WRADDR = 16'h1000; bus.BYTEEN = 4'hF; bus.WDATA = 32'h55; bus.WREN = 1'b1;
    bus.RDADDR = 16'h1000; bus.RDEN = 1'b1;
    exp_q.push_back(32'h0ABC_DEF0); name_q.push_back("same_cycle_wr_rd");
    tick(1);
    bus.WREN = 1'b0; bus.RDEN = 1'b0;
    rd(16'h1000, 32'h55, "after_same_cycle");
  endtask

  task automatic test_capctrl;
    wr(16'h1104, 4'b0001, 32'h1);
    n_vec++; if (CAPON[1] !== 1'b0) begin n_err++; $display("FAIL capon1_midframe: got %b required 0", CAPON[1]); end
    rd(16'h1104, 32'h1, "capctrl1_req");
    VSYNC[1] = 1'b0;
    tick(2);
    n_vec++; if (CAPON[1] !== 1'b0) begin n_err++; $display("FAIL capon1_before_vne: got %b required 0", CAPON[1]); end
    tick(1);
    n_vec++; if (CAPON !== 2'b10) begin n_err++; $display("FAIL capon_on_vne: got %b required 10", CAPON); end
    VSYNC[1] = 1'b1;
    rd(16'h1104, 32'h3, "capctrl1_cblank");
    wr(16'h1104, 4'b0001, 32'h2);
    rd(16'h1104, 32'h0, "capctrl1_cblank_clr");
    n_vec++; if (CAPON[1] !== 1'b1) begin n_err++; $display("FAIL capon1_holds: got %b required 1", CAPON[1]); end
    wr(16'h1104, 4'b0001, 32'h1);
    tick(2);
  endtask

  task automatic test_vint;
    wr(16'h1008, 4'b0001, 32'h1);
    VSYNC[0] = 1'b0;
    tick(3);
    n_vec++; if (CAP_IRQ !== 1'b0) begin n_err++; $display("FAIL irq_latency: got %b required 0", CAP_IRQ); end
    tick(1);
    n_vec++; if (CAP_IRQ !== 1'b1) begin n_err++; $display("FAIL irq_vint: got %b required 1", CAP_IRQ); end
    rd(16'h1008, 32'h3, "capint0_vint");
    VSYNC[0] = 1'b1;
    tick(3);
    VSYNC[0] = 1'b0;
    tick(2);
    wr(16'h1008, 4'b0001, 32'h3);
    rd(16'h1008, 32'h3, "vint_set_beats_clr");
    VSYNC[0] = 1'b1;
    tick(3);
    wr(16'h1008, 4'b0001, 32'h3);
    rd(16'h1008, 32'h1, "vint_w1c");
    n_vec++; if (CAP_IRQ !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b required 0", CAP_IRQ); end
    wr(16'h1008, 4'b0001, 32'h0);
  endtask

  task automatic test_fifo;
    BUF_OVER[1] = 1'b1; tick(1); BUF_OVER[1] = 1'b0;
    rd(16'h110C, 32'h2, "capfifo1_over");
    tick(1);
    n_vec++; if (CAP_IRQ !== 1'b0) begin n_err++; $display("FAIL irq_eie_off: got %b required 0", CAP_IRQ); end
    wr(16'h110C, 4'b0001, 32'h2);
    rd(16'h110C, 32'h0, "capfifo1_w1c");
    wr(16'h1108, 4'b0001, 32'h4);
    BUF_OVER[1] = 1'b1; tick(1); BUF_OVER[1] = 1'b0;
    rd(16'h1108, 32'hC, "capint1_eint");
    n_vec++; if (CAP_IRQ !== 1'b1) begin n_err++; $display("FAIL irq_eint: got %b required 1", CAP_IRQ); end
    BUF_UNDER[0] = 1'b1; tick(1); BUF_UNDER[0] = 1'b0;
    rd(16'h100C, 32'h1, "capfifo0_under");
    wr(16'h1108, 4'b0001, 32'hC);
    rd(16'h1108, 32'h4, "eint_w1c");
    tick(1);
    n_vec++; if (CAP_IRQ !== 1'b0) begin n_err++; $display("FAIL irq_eint_clear: got %b required 0", CAP_IRQ); end
    wr(16'h110C, 4'b0001, 32'h3);
    wr(16'h100C, 4'b0001, 32'h3);
    rd(16'h110C, 32'h0, "capfifo1_clear_all");
  endtask

  task automatic test_decode;
    rd(16'h1300, 32'h0, "ch3_reads_zero");
    rd(16'h1000, 32'h55, "ch0_capaddr");
    rd(16'h2000, 32'h55, "block_miss_holds");
    rd(16'h1014, 32'h0, "offset5_zero");
    wr(16'h2000, 4'hF, 32'h0);
    wr(16'h1300, 4'hF, 32'hFFFF_FFFF);
    rd(16'h1000, 32'h55, "miss_write_ignored");
    rd(16'h1010, 32'h0, "frmcnt0_zero");
  endtask

  task automatic test_frmcnt;
    wr(16'h1110, 4'hF, 32'h5);
    rd(16'h1110, 32'h0, "frmcnt1_after_write");
`ifdef CAP_FRMCNT_EN
    for (int i = 0; i < 65537; i++) begin
      VSYNC[1] = 1'b0; tick(1);
      VSYNC[1] = 1'b1; tick(1);
    end
    tick(4);
    n_vec++; if (CAPON[1] !== 1'b1) begin n_err++; $display("FAIL capon1_frmcnt: got %b required 1", CAPON[1]); end
    rd(16'h1110, 32'h1, "frmcnt1_wrap");
`endif
  endtask

  task automatic test_reset_mid;
    n_vec++; if (CAPON !== 2'b10) begin n_err++; $display("FAIL capon_before_rst: got %b required 10", CAPON); end
    n_vec++; if (CAPADDR[28:0] !== 29'h55) begin n_err++; $display("FAIL capaddr_before_rst: got %h required 55", CAPADDR[28:0]); end
    @(posedge ACLK); #3;
    ARST = 1'b0;
    VSYNC[0] = 1'b0;
    #1;
    n_vec++; if (CAPON !== '0)   begin n_err++; $display("FAIL async_rst_capon: got %b required 0", CAPON); end
    n_vec++; if (CAPADDR !== '0) begin n_err++; $display("FAIL async_rst_capaddr: got %h required 0", CAPADDR); end
    n_vec++; if (bus.RDATA !== '0) begin n_err++; $display("FAIL async_rst_rdata: got %h required 0", bus.RDATA); end
    #12;
    ARST = 1'b1;
    tick(6);
    n_vec++; if (CAPON !== '0) begin n_err++; $display("FAIL capon_after_release: got %b required 0", CAPON); end
    rd(16'h1004, 32'h0, "no_vne_ch0_release");
    rd(16'h1104, 32'h0, "no_vne_ch1_release");
    VSYNC[0] = 1'b1;
    tick(3);
  endtask

  initial begin
    test_reset();
    test_capaddr();
    test_capctrl();
    test_vint();
    test_fifo();
    test_decode();
    test_frmcnt();
    test_reset_mid();
    tick(3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
